// File: rtl/cross_bar_slave_mem.sv
// Crossbar slave backed by a word-addressed memory. Each request is acknowledged
// for one cycle after a configurable number of wait cycles.
module cross_bar_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_req,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic                  s_cmd,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    output logic                  s_ack,
    output logic [DATA_WIDTH-1:0] s_rdata
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [3:0] LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;
    logic [3:0]              cnt_nxt;
    logic [IDX_W-1:0]        idx_p0;
    logic                    cmd_p0;
    logic [DATA_WIDTH-1:0]   wdata_p0;
    logic                    ack_nxt;
    logic [DATA_WIDTH-1:0]   rdata_nxt;
    logic [IDX_W-1:0]        rd_idx;
    logic                    rd_cmd;
    logic                    unused_addr;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    // Byte address to word index; low byte-lane bits and high bits alias away.
    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[IDX_W+1:2];
    endfunction

    assign unused_addr = ^s_addr;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack_nxt   = 1'b0;
        rdata_nxt = '0;
        rd_idx    = idx_p0;
        rd_cmd    = cmd_p0;
        case (state)
            IDLE: begin
                if (s_req) begin
                    // With zero latency RESP follows acceptance directly, so use live inputs.
                    rd_idx    = word_index(s_addr);
                    rd_cmd    = s_cmd;
                    cnt_nxt   = LAT_LOAD;
                    state_nxt = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == RESP) begin
            ack_nxt = 1'b1;
            if (!rd_cmd) begin
                rdata_nxt = mem[rd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            idx_p0   <= '0;
            cmd_p0   <= 1'b0;
            wdata_p0 <= '0;
            s_ack    <= 1'b0;
            s_rdata  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            s_ack   <= ack_nxt;
            s_rdata <= rdata_nxt;
            if (state == IDLE && s_req) begin
                idx_p0   <= word_index(s_addr);
                cmd_p0   <= s_cmd;
                wdata_p0 <= s_wdata;
            end
        end
    end

    // Write commits at the edge closing RESP; reset forces IDLE first, so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (state == RESP && cmd_p0) begin
            mem[idx_p0] <= wdata_p0;
        end
    end

endmodule

// File: doc/cross_bar_slave_mem.md
CROSS_BAR_SLAVE_MEM -- requirements
Module: cross_bar_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, write/read data width.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, number of DATA_WIDTH words; power of two, >= 2.
REQ-004 SHALL have parameter LATENCY, default 2, wait cycles inserted before acknowledge; range 0..15.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port s_req, input, 1, master request; held high until acknowledged.
REQ-008 SHALL have port s_addr, input, ADDR_WIDTH, byte address.
REQ-009 SHALL have port s_cmd, input, 1, 0 = read, 1 = write.
REQ-010 SHALL have port s_wdata, input, DATA_WIDTH, write data.
REQ-011 SHALL have port s_ack, output, 1, one-cycle acknowledge.
REQ-012 SHALL have port s_rdata, output, DATA_WIDTH, read data, valid only while s_ack=1.

Function
REQ-013 SHALL implement the crossbar slave side: the master holds s_req, s_addr, s_cmd, s_wdata stable from request until the edge sampling s_ack=1.
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; all outputs registered (Moore).
REQ-015 In IDLE, an edge sampling s_req=1 SHALL latch s_addr, s_cmd, s_wdata, load wait counter with LATENCY-1 and enter WAIT, or enter RESP directly when LATENCY=0.
REQ-016 In WAIT the counter SHALL decrement each edge; at counter 0 the next edge enters RESP.
REQ-017 In RESP s_ack SHALL be 1 for exactly one cycle; the next edge returns to IDLE unconditionally.
REQ-018 Latency: request first sampled at edge N -> s_ack high during cycle N+1+LATENCY.
REQ-019 s_req SHALL be ignored in WAIT and RESP; a request still high in the IDLE cycle after RESP is a new transaction (one-cycle bubble between transactions).
REQ-020 Word index SHALL be latched addr[log2(MEM_DEPTH)+1:2]; bits [1:0] and upper bits ignored (addresses alias modulo MEM_DEPTH*4).
REQ-021 Write: memory word updated at the edge ending the RESP cycle; s_rdata = 0 during a write ack.
REQ-022 Read: s_rdata = memory word at latched index during RESP; write-then-read of the same word SHALL return new data.
REQ-023 s_rdata SHALL be 0 whenever s_ack=0.
REQ-024 s_addr/s_wdata/s_cmd changes after acceptance SHALL NOT affect the transaction in flight.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state IDLE, counter 0, latched request 0, s_ack=0, s_rdata=0.
REQ-026 Reset asserted during WAIT or RESP SHALL abandon the transaction without writing memory.
REQ-027 Memory contents are not reset; contents are retained across rst_n assertion and undefined after power-up.
REQ-028 First request SHALL be accepted at the first edge after rst_n deasserts with s_req=1.

Verification (LATENCY=2, MEM_DEPTH=256 unless stated)
REQ-029 Write 0x0000_0010 <- 0xA5A5_5A5A, req sampled edge N -> s_ack=1, s_rdata=0 in cycle N+3 only; then read 0x10 -> s_rdata=0xA5A5_5A5A with its ack.
REQ-030 Alias: write 0x0000_0404 <- 0x1234_5678, read 0x0000_0004 -> 0x1234_5678; read 0x0000_0007 -> 0x1234_5678.
REQ-031 Back-to-back: s_req held high across 3 reads -> acks in cycles N+3, N+7, N+11, each with correct data.
REQ-032 LATENCY=0: req sampled edge N -> s_ack in cycle N+1; LATENCY=15 -> s_ack in cycle N+16.
REQ-033 Reset mid-write: write 0x20 <- 0xFFFF_FFFF, rst_n low in WAIT -> s_ack never asserts; after reset, read 0x20 returns prior content (pre-written 0x0000_0001).
REQ-034 Inputs toggled during WAIT (s_addr, s_wdata, s_cmd randomised) -> response matches values latched at acceptance.
